// File: rtl/mdu_issue_queue_pkg.sv
// Shared types and constants for the MDU issue queue: the queued micro-op
// record, default geometry, and the wakeup-merge helper.
package mdu_issue_queue_pkg;

  localparam int MDU_IQ_DEPTH = 4;
  localparam int PRF_W        = 6;
  localparam int ROB_W        = 5;

  typedef enum logic [3:0] {
    MDU_MUL    = 4'd0,
    MDU_MULH   = 4'd1,
    MDU_MULHSU = 4'd2,
    MDU_MULHU  = 4'd3,
    MDU_DIV    = 4'd4,
    MDU_DIVU   = 4'd5,
    MDU_REM    = 4'd6,
    MDU_REMU   = 4'd7
  } mdu_op_e;

  typedef struct packed {
    mdu_op_e          op;
    logic [ROB_W-1:0] rob_id;
    logic [PRF_W-1:0] dst_prf;
    logic [PRF_W-1:0] src0_prf;
    logic             src0_rdy;
    logic [PRF_W-1:0] src1_prf;
    logic             src1_rdy;
  } MDU_Queue_Meta;

  // Ready bits are sticky: a hit only ever sets them.
  function automatic MDU_Queue_Meta mdu_meta_wake(MDU_Queue_Meta m, logic hit0, logic hit1);
    MDU_Queue_Meta r;
    r          = m;
    r.src0_rdy = m.src0_rdy | hit0;
    r.src1_rdy = m.src1_rdy | hit1;
    return r;
  endfunction

endpackage

// File: rtl/mdu_issue_queue_if.sv
// Dispatch-write, wakeup and issue signals of the MDU issue queue.
// master = dispatch/MDU side, slave = the queue.
interface mdu_issue_queue_if #(
  parameter int WAKE_N = 2,
  parameter int PRF_W  = mdu_issue_queue_pkg::PRF_W
) ();

  logic                             rs_mdu_wen_0;
  mdu_issue_queue_pkg::MDU_Queue_Meta rs_mdu_dout_0;
  logic                             rs_mdu_ready;
  logic [WAKE_N-1:0]                wake_vld;
  logic [WAKE_N-1:0][PRF_W-1:0]     wake_prf;
  logic                             mdu_busy;
  logic                             issue_vld;
  mdu_issue_queue_pkg::MDU_Queue_Meta issue_op;

  modport master (
    output rs_mdu_wen_0, rs_mdu_dout_0, wake_vld, wake_prf, mdu_busy,
    input  rs_mdu_ready, issue_vld, issue_op
  );

  modport slave (
    input  rs_mdu_wen_0, rs_mdu_dout_0, wake_vld, wake_prf, mdu_busy,
    output rs_mdu_ready, issue_vld, issue_op
  );

endinterface

// File: rtl/mdu_iq_wakeup_cmp.sv
// Matches one physical register index against every wakeup broadcast port.
module mdu_iq_wakeup_cmp #(
  parameter int WAKE_N = 2,
  parameter int PRF_W  = 6
) (
  input  logic [PRF_W-1:0]             prf_i,
  input  logic [WAKE_N-1:0]            wake_vld_i,
  input  logic [WAKE_N-1:0][PRF_W-1:0] wake_prf_i,
  output logic                         hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int k = 0; k < WAKE_N; k++) begin
      if (wake_vld_i[k] && (wake_prf_i[k] == prf_i)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdu_issue_queue.sv
// In-order MDU issue queue: circular buffer with wakeup tracking and oldest-first issue.
// Optional MDU_IQ_WAKEUP_BYPASS_EN lets the head issue in the same cycle it is woken.
module mdu_issue_queue
  import mdu_issue_queue_pkg::MDU_Queue_Meta;
  import mdu_issue_queue_pkg::mdu_meta_wake;
#(
  parameter int DEPTH  = mdu_issue_queue_pkg::MDU_IQ_DEPTH,
  parameter int PRF_W  = mdu_issue_queue_pkg::PRF_W,
  parameter int WAKE_N = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  mdu_issue_queue_if.slave   iq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  MDU_Queue_Meta    ent_q [DEPTH];
  MDU_Queue_Meta    ent_d [DEPTH];
  logic             issue_vld_q, issue_vld_d;
  MDU_Queue_Meta    issue_op_q, issue_op_d;

  logic [DEPTH-1:0] hit0, hit1;
  logic             wr_hit0, wr_hit1;
  logic             full, wr_en, issue_go;
  logic             head_rdy0, head_rdy1;
  MDU_Queue_Meta    head_ent;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent_cmp
    mdu_iq_wakeup_cmp #(.WAKE_N(WAKE_N), .PRF_W(PRF_W)) u_cmp_src0 (
      .prf_i      (ent_q[i].src0_prf),
      .wake_vld_i (iq.wake_vld),
      .wake_prf_i (iq.wake_prf),
      .hit_o      (hit0[i])
    );
    mdu_iq_wakeup_cmp #(.WAKE_N(WAKE_N), .PRF_W(PRF_W)) u_cmp_src1 (
      .prf_i      (ent_q[i].src1_prf),
      .wake_vld_i (iq.wake_vld),
      .wake_prf_i (iq.wake_prf),
      .hit_o      (hit1[i])
    );
  end

  // The incoming op is compared too, so a broadcast in its write cycle is not missed.
  mdu_iq_wakeup_cmp #(.WAKE_N(WAKE_N), .PRF_W(PRF_W)) u_cmp_wr_src0 (
    .prf_i      (iq.rs_mdu_dout_0.src0_prf),
    .wake_vld_i (iq.wake_vld),
    .wake_prf_i (iq.wake_prf),
    .hit_o      (wr_hit0)
  );
  mdu_iq_wakeup_cmp #(.WAKE_N(WAKE_N), .PRF_W(PRF_W)) u_cmp_wr_src1 (
    .prf_i      (iq.rs_mdu_dout_0.src1_prf),
    .wake_vld_i (iq.wake_vld),
    .wake_prf_i (iq.wake_prf),
    .hit_o      (wr_hit1)
  );

  assign full            = (count_q == CNT_W'(DEPTH));
  assign iq.rs_mdu_ready = !full;
  assign wr_en           = iq.rs_mdu_wen_0 && !full;
  assign head_ent        = ent_q[head_q];

`ifdef MDU_IQ_WAKEUP_BYPASS_EN
  assign head_rdy0 = head_ent.src0_rdy | hit0[head_q];
  assign head_rdy1 = head_ent.src1_rdy | hit1[head_q];
`else
  assign head_rdy0 = head_ent.src0_rdy;
  assign head_rdy1 = head_ent.src1_rdy;
`endif

  assign issue_go = (count_q != '0) && head_rdy0 && head_rdy1 && !iq.mdu_busy;

  always_comb begin
    ent_d       = ent_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    issue_vld_d = 1'b0;
    issue_op_d  = issue_op_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Stale slots may also pick up ready bits; a write overwrites them before use.
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = mdu_meta_wake(ent_q[i], hit0[i], hit1[i]);
      end

      if (wr_en) begin
        ent_d[tail_q] = mdu_meta_wake(iq.rs_mdu_dout_0, wr_hit0, wr_hit1);
        tail_d        = tail_q + 1'b1;
      end

      if (issue_go) begin
        issue_vld_d         = 1'b1;
        issue_op_d          = head_ent;
        issue_op_d.src0_rdy = 1'b1;
        issue_op_d.src1_rdy = 1'b1;
        head_d              = head_q + 1'b1;
      end

      case ({wr_en, issue_go})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      issue_vld_q <= 1'b0;
      issue_op_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      issue_vld_q <= issue_vld_d;
      issue_op_q  <= issue_op_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign iq.issue_vld = issue_vld_q;
  assign iq.issue_op  = issue_op_q;

  // Dispatch must never write while the queue reports no free slot.
  a_no_write_when_full: assert property (
    @(posedge clk) disable iff (!rst) !(iq.rs_mdu_wen_0 && full)
  );

endmodule

// File: tb/tb_mdu_issue_queue.sv
// Randomized and directed bench for mdu_issue_queue against a queue-based reference model.
module tb_mdu_issue_queue;
  import mdu_issue_queue_pkg::*;

  localparam int NW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  mdu_issue_queue_if #(.WAKE_N(NW), .PRF_W(PRF_W)) iq_if ();

  mdu_issue_queue #(.DEPTH(MDU_IQ_DEPTH), .PRF_W(PRF_W), .WAKE_N(NW)) dut (
    .clk   (clk),
    .rst   (rst_n),
    .flush (flush),
    .iq    (iq_if)
  );

  MDU_Queue_Meta mq[$];
  logic          exp_vld;
  MDU_Queue_Meta exp_op;
  int            total    = 0;
  int            bad      = 0;
  int            n_issued = 0;
  string         phase    = "init";

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic woke(input logic [PRF_W-1:0] p, input logic [NW-1:0] wv,
                                input logic [NW-1:0][PRF_W-1:0] wp);
    for (int k = 0; k < NW; k++) begin
      if (wv[k] && wp[k] == p) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic MDU_Queue_Meta mk(input logic [PRF_W-1:0] p0, input logic r0,
                                       input logic [PRF_W-1:0] p1, input logic r1);
    MDU_Queue_Meta m;
    m.op       = mdu_op_e'(4'($urandom_range(0, 7)));
    m.rob_id   = ROB_W'($urandom);
    m.dst_prf  = PRF_W'($urandom);
    m.src0_prf = p0;
    m.src0_rdy = r0;
    m.src1_prf = p1;
    m.src1_rdy = r1;
    return m;
  endfunction

  // Check last cycle's outcome, drive this cycle's inputs, advance the model by one edge.
  task automatic step(input logic wen, input MDU_Queue_Meta din, input logic [NW-1:0] wv,
                      input logic [NW-1:0][PRF_W-1:0] wp, input logic busy, input logic fl);
    MDU_Queue_Meta e;
    logic          r0, r1, go, can_wr;
    @(negedge clk);
    chk_val({phase, ".ready"}, 64'(iq_if.rs_mdu_ready), 64'(mq.size() < MDU_IQ_DEPTH));
    chk_val({phase, ".vld"},   64'(iq_if.issue_vld),    64'(exp_vld));
    chk_val({phase, ".op"},    64'(iq_if.issue_op),     64'(exp_op));
    if (iq_if.issue_vld === 1'b1) n_issued++;

    iq_if.rs_mdu_wen_0  = wen;
    iq_if.rs_mdu_dout_0 = din;
    iq_if.wake_vld      = wv;
    iq_if.wake_prf      = wp;
    iq_if.mdu_busy      = busy;
    flush               = fl;

    can_wr = (mq.size() < MDU_IQ_DEPTH);
    if (fl) begin
      mq.delete();
      exp_vld = 1'b0;
    end else begin
      go = 1'b0;
      if (mq.size() > 0) begin
        r0 = mq[0].src0_rdy;
        r1 = mq[0].src1_rdy;
`ifdef MDU_IQ_WAKEUP_BYPASS_EN
        r0 = r0 | woke(mq[0].src0_prf, wv, wp);
        r1 = r1 | woke(mq[0].src1_prf, wv, wp);
`endif
        go = r0 && r1 && !busy;
      end
      if (go) begin
        exp_op          = mq.pop_front();
        exp_op.src0_rdy = 1'b1;
        exp_op.src1_rdy = 1'b1;
        exp_vld         = 1'b1;
      end else begin
        exp_vld = 1'b0;
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (woke(mq[i].src0_prf, wv, wp)) mq[i].src0_rdy = 1'b1;
        if (woke(mq[i].src1_prf, wv, wp)) mq[i].src1_rdy = 1'b1;
      end
      if (wen && can_wr) begin
        e = din;
        if (woke(e.src0_prf, wv, wp)) e.src0_rdy = 1'b1;
        if (woke(e.src1_prf, wv, wp)) e.src1_rdy = 1'b1;
        mq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input logic busy);
    repeat (n) step(1'b0, '0, '0, '0, busy, 1'b0);
  endtask

  task automatic wr(input MDU_Queue_Meta m, input logic busy);
    step(1'b1, m, '0, '0, busy, 1'b0);
  endtask

  // Reset between edges and check that state is discarded before any clock edge.
  task automatic do_reset(input string tag);
    #1;
    iq_if.rs_mdu_wen_0 = 1'b0;
    iq_if.wake_vld     = '0;
    iq_if.mdu_busy     = 1'b0;
    flush              = 1'b0;
    rst_n              = 1'b0;
    #1;
    chk_val({tag, ".ready"}, 64'(iq_if.rs_mdu_ready), 64'(1'b1));
    chk_val({tag, ".vld"},   64'(iq_if.issue_vld),    64'(1'b0));
    chk_val({tag, ".op"},    64'(iq_if.issue_op),     64'(0));
    mq.delete();
    exp_vld = 1'b0;
    exp_op  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    MDU_Queue_Meta m;
    logic          wen, busy, fl;
    logic [NW-1:0] wv;
    logic [NW-1:0][PRF_W-1:0] wp;

    iq_if.rs_mdu_wen_0  = 1'b0;
    iq_if.rs_mdu_dout_0 = '0;
    iq_if.wake_vld      = '0;
    iq_if.wake_prf      = '0;
    iq_if.mdu_busy      = 1'b0;
    exp_vld             = 1'b0;
    exp_op              = '0;

    @(negedge clk);
    do_reset("reset");

    phase = "ready_op";
    n_issued = 0;
    wr(mk(6'd1, 1'b1, 6'd2, 1'b1), 1'b0);
    idle(4, 1'b0);
    chk_val("ready_op.pulses", 64'(n_issued), 64'(1));

    phase = "fill";
    n_issued = 0;
    for (int i = 0; i < MDU_IQ_DEPTH; i++) wr(mk(6'(i), 1'b1, 6'(i + 8), 1'b1), 1'b1);
    idle(2, 1'b1);
    chk_val("fill.full", 64'(iq_if.rs_mdu_ready), 64'(1'b0));
    idle(6, 1'b0);
    chk_val("fill.pulses", 64'(n_issued), 64'(MDU_IQ_DEPTH));

    phase = "wake_wr";
    n_issued = 0;
    step(1'b1, mk(6'd3, 1'b1, 6'd9, 1'b0), 2'b10, {6'd9, 6'd4}, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk_val("wake_wr.pulses", 64'(n_issued), 64'(1));

    phase = "head_block";
    n_issued = 0;
    wr(mk(6'd5, 1'b0, 6'd6, 1'b1), 1'b0);
    wr(mk(6'd7, 1'b1, 6'd8, 1'b1), 1'b0);
    idle(3, 1'b0);
    chk_val("head_block.held", 64'(n_issued), 64'(0));
    step(1'b0, '0, 2'b01, {6'd0, 6'd5}, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk_val("head_block.pulses", 64'(n_issued), 64'(2));

    phase = "flush_wr";
    n_issued = 0;
    for (int i = 0; i < 3; i++) wr(mk(6'(i), 1'b1, 6'(i), 1'b1), 1'b1);
    step(1'b1, mk(6'd1, 1'b1, 6'd1, 1'b1), '0, '0, 1'b1, 1'b1);
    idle(4, 1'b0);
    chk_val("flush_wr.pulses", 64'(n_issued), 64'(0));

    phase = "rst_mid";
    for (int i = 0; i < MDU_IQ_DEPTH; i++) wr(mk(6'(i), 1'b1, 6'(i), 1'b1), 1'b1);
    do_reset("rst_mid");
    idle(3, 1'b0);

    phase = "random";
    for (int c = 0; c < 3000; c++) begin
      wen  = (mq.size() < MDU_IQ_DEPTH) && ($urandom_range(0, 3) != 0);
      busy = ($urandom_range(0, 2) == 0);
      fl   = ($urandom_range(0, 59) == 0);
      wv   = NW'($urandom_range(0, 3));
      for (int k = 0; k < NW; k++) wp[k] = PRF_W'($urandom_range(0, 15));
      m = mk(PRF_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             PRF_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      step(wen, m, wv, wp, busy, fl);
    end
    idle(8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
